// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one uart_tx byte transmitter
//
// Build option: UART_TX_ARB_CRLF_EN appends CR LF (8'h0D, 8'h0A) to every packet,
// aborted packets included, before the grant is released.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   req       per-source packet request, held until the packet's final ack
//   req_data  current byte of each source, source i at [8i+7:8i]
//   req_last  current byte of source i is the last of its packet
//   req_ack   one-cycle pulse to the granted source once its byte has been sent
//   grant     one-hot transmitter owner, all-zero when idle
//   tx_start  one-cycle start pulse to uart_tx
//   tx_din    byte to uart_tx, held until the next start
//   tx_busy   uart_tx busy
//   tx_done   uart_tx one-cycle completion pulse
//   arb_busy  OR of grant

module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_din,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 arb_busy
);

`ifdef UART_TX_ARB_CRLF_EN
    typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, CR, LF} state_t;
    // WAIT is shared by data, CR and LF bytes; phase tells it what follows tx_done.
    typedef enum logic [1:0] {PH_DATA, PH_CR, PH_LF} phase_t;
    phase_t phase, phase_d;
`else
    typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;
`endif

    state_t             state, state_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   gidx, gidx_d;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   ptr_next;
    logic               sel_found;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               start_d;
    logic [7:0]         din_d;
    logic               busy_d;
    logic [7:0]         cur_data;
    logic               cur_last;
    logic               cur_req;
    int                 j;

    assign cur_data = req_data[{gidx, 3'b000} +: 8];
    assign cur_last = req_last[gidx];
    assign cur_req  = req[gidx];
    assign ptr_next = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

    // First requester at or above the pointer, wrapping past NUM_REQ-1 to 0.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!sel_found && req[IDX_W'(j)]) begin
                sel_found = 1'b1;
                sel       = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gidx_d  = gidx;
        last_d  = last_q;
        grant_d = grant;
        ack_d   = '0;
        start_d = 1'b0;
        din_d   = tx_din;
`ifdef UART_TX_ARB_CRLF_EN
        phase_d = phase;
`endif
        case (state)
            IDLE: begin
                if (sel_found && !tx_busy) begin
                    gidx_d  = sel;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                    state_d = SEND;
                end
            end
            SEND: begin
                start_d = 1'b1;
                din_d   = cur_data;
                last_d  = cur_last;
                state_d = WAIT;
`ifdef UART_TX_ARB_CRLF_EN
                phase_d = PH_DATA;
`endif
            end
            WAIT: begin
                if (tx_done) begin
`ifdef UART_TX_ARB_CRLF_EN
                    case (phase)
                        PH_DATA: begin
                            ack_d   = grant;
                            state_d = ACK;
                        end
                        PH_CR: begin
                            state_d = LF;
                        end
                        default: begin
                            grant_d = '0;
                            ptr_d   = ptr_next;
                            state_d = IDLE;
                        end
                    endcase
`else
                    ack_d   = grant;
                    state_d = ACK;
`endif
                end
            end
            ACK: begin
                // A dropped req ends the packet after the byte already sent.
                if (last_q || !cur_req) begin
`ifdef UART_TX_ARB_CRLF_EN
                    state_d = CR;
`else
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
`endif
                end else begin
                    state_d = SEND;
                end
            end
`ifdef UART_TX_ARB_CRLF_EN
            CR: begin
                start_d = 1'b1;
                din_d   = 8'h0D;
                phase_d = PH_CR;
                state_d = WAIT;
            end
            LF: begin
                start_d = 1'b1;
                din_d   = 8'h0A;
                phase_d = PH_LF;
                state_d = WAIT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            last_q   <= 1'b0;
            grant    <= '0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_din   <= 8'h00;
            arb_busy <= 1'b0;
`ifdef UART_TX_ARB_CRLF_EN
            phase    <= PH_DATA;
`endif
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            gidx     <= gidx_d;
            last_q   <= last_d;
            grant    <= grant_d;
            req_ack  <= ack_d;
            tx_start <= start_d;
            tx_din   <= din_d;
            arb_busy <= busy_d;
`ifdef UART_TX_ARB_CRLF_EN
            phase    <= phase_d;
`endif
        end
    end

endmodule
